// File: rtl/branch_cc_ctrl.sv
// branch_cc_ctrl: LC-3 condition-code / branch-enable sequencer between the IR and the NZP/BEN unit.
// Defining BRANCH_CC_CTRL_STATS_EN adds the saturating br_total / br_taken counters.
module branch_cc_ctrl (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] IR,
  input  logic        mem_rdy,
  input  logic        BEN,
  output logic        LD_CC,
  output logic        LD_BEN,
  output logic        LD_PC,
  output logic [1:0]  PCMUX,
  output logic        taken,
  output logic        done
`ifdef BRANCH_CC_CTRL_STATS_EN
  ,
  output logic [15:0] br_total,
  output logic [15:0] br_taken
`endif
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECODE   = 3'd1,
    S_MEM_WAIT = 3'd2,
    S_CC_UPD   = 3'd3,
    S_BEN_LD   = 3'd4,
    S_BEN_EVAL = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [1:0]  mem_cnt_q, mem_cnt_d;
  logic        taken_q, taken_d;

  // Only opcode and nzp fields steer the sequence; the rest of the word is carried but unused.
  logic unused_ir_s;
  assign unused_ir_s = ^ir_q[8:0];

  // State and datapath registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      ir_q      <= 16'h0000;
      mem_cnt_q <= 2'd0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      mem_cnt_q <= mem_cnt_d;
      taken_q   <= taken_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    mem_cnt_d   = mem_cnt_q;
    taken_d     = taken_q;
    instr_ready = 1'b0;
    LD_CC       = 1'b0;
    LD_BEN      = 1'b0;
    LD_PC       = 1'b0;
    PCMUX       = 2'b00;
    taken       = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_d    = IR;
          state_d = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DECODE: begin
        case (ir_q[15:12])
          4'b0000: begin
            if (ir_q[11:9] != 3'b000) begin
              state_d = S_BEN_LD;
            end else begin
              state_d = S_DONE;
            end
          end
          4'b0001, 4'b0101, 4'b1001, 4'b1110: state_d = S_CC_UPD;
          4'b0010, 4'b0110: begin
            mem_cnt_d = 2'd1;
            state_d   = S_MEM_WAIT;
          end
          4'b1010: begin
            mem_cnt_d = 2'd2;
            state_d   = S_MEM_WAIT;
          end
          default: state_d = S_DONE;
        endcase
      end

      // Non-consecutive strobes are fine; only cycles with mem_rdy high count down.
      S_MEM_WAIT: begin
        if (mem_rdy) begin
          mem_cnt_d = mem_cnt_q - 2'd1;
          if (mem_cnt_q <= 2'd1) begin
            state_d = S_CC_UPD;
          end else begin
            state_d = S_MEM_WAIT;
          end
        end else begin
          state_d = S_MEM_WAIT;
        end
      end

      S_CC_UPD: begin
        LD_CC   = 1'b1;
        state_d = S_DONE;
      end

      S_BEN_LD: begin
        LD_BEN  = 1'b1;
        state_d = S_BEN_EVAL;
      end

      S_BEN_EVAL: begin
        if (BEN) begin
          LD_PC   = 1'b1;
          PCMUX   = 2'b10;
          taken_d = 1'b1;
        end else begin
          taken_d = taken_q;
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        taken   = taken_q;
        taken_d = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

`ifdef BRANCH_CC_CTRL_STATS_EN
  logic [15:0] br_total_q;
  logic [15:0] br_taken_q;

  // Saturating branch statistics, updated when BEN is evaluated.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      br_total_q <= 16'h0000;
      br_taken_q <= 16'h0000;
    end else if (state_q == S_BEN_EVAL) begin
      if (br_total_q != 16'hFFFF) begin
        br_total_q <= br_total_q + 16'd1;
      end
      if (BEN && (br_taken_q != 16'hFFFF)) begin
        br_taken_q <= br_taken_q + 16'd1;
      end
    end
  end

  assign br_total = br_total_q;
  assign br_taken = br_taken_q;
`endif

endmodule

// File: tb/tb_branch_cc_ctrl.sv
// Scoreboard bench for branch_cc_ctrl: randomized instructions checked against a latency/strobe model.
module tb_branch_cc_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] IR = 16'h0000;
  logic        mem_rdy = 1'b0;
  logic        BEN = 1'b0;
  logic        instr_ready, LD_CC, LD_BEN, LD_PC, taken, done;
  logic [1:0]  PCMUX;
`ifdef BRANCH_CC_CTRL_STATS_EN
  logic [15:0] br_total, br_taken;
`endif

  branch_cc_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .IR(IR), .mem_rdy(mem_rdy), .BEN(BEN), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
    .LD_PC(LD_PC), .PCMUX(PCMUX), .taken(taken), .done(done)
`ifdef BRANCH_CC_CTRL_STATS_EN
    , .br_total(br_total), .br_taken(br_taken)
`endif
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected response: cycles (relative to the accept edge, 0 = none) of each strobe and of done.
  typedef struct {
    int base;
    int cc;
    int ben;
    int pc;
    int dn;
    bit tk;
  } exp_t;

  exp_t sb[$];
  int m_total = 0;
  int m_taken = 0;

  function automatic exp_t model(input logic [15:0] ir, input bit b, input int p1, input int p2, input int base);
    exp_t e;
    e.base = base; e.cc = 0; e.ben = 0; e.pc = 0; e.dn = 2; e.tk = 1'b0;
    case (ir[15:12])
      4'h0: if (ir[11:9] != 3'b000) begin
        e.ben = 2; e.dn = 4; e.tk = b; e.pc = b ? 3 : 0;
      end
      4'h1, 4'h5, 4'h9, 4'hE: begin e.cc = 2; e.dn = 3; end
      4'h2, 4'h6: begin e.cc = p1 + 1; e.dn = p1 + 2; end
      4'hA: begin e.cc = p2 + 1; e.dn = p2 + 2; end
      default: ;
    endcase
    return e;
  endfunction

  // Issue one instruction at a negedge, then drive mem_rdy/BEN until the controller is idle again.
  task automatic issue(input logic [15:0] ir, input bit b, input int p1, input int p2);
    int base;
    int k;
    logic [3:0] op;
    bit is_mem;
    op = ir[15:12];
    is_mem = (op == 4'h2) || (op == 4'h6) || (op == 4'hA);
    k = 0;
    while (!instr_ready && k < 100) begin
      @(negedge Clk);
      k++;
    end
    if (!instr_ready) begin
      check("ready_timeout", instr_ready, 1);
      return;
    end
    base = cyc;
    instr_valid = 1'b1;
    IR = ir;
    mem_rdy = 1'($urandom_range(0, 1));
    BEN = 1'($urandom_range(0, 1));
    sb.push_back(model(ir, b, p1, p2, base));
    if (op == 4'h0 && ir[11:9] != 3'b000) begin
      if (m_total < 65535) m_total++;
      if (b && m_taken < 65535) m_taken++;
    end
    forever begin
      @(negedge Clk);
      k = cyc - base;
      instr_valid = 1'b0;
      IR = 16'($urandom);
      BEN = (k == 3) ? b : 1'($urandom_range(0, 1));
      if (is_mem) begin
        if (k == 1) mem_rdy = 1'($urandom_range(0, 1));
        else mem_rdy = (k == p1) || (op == 4'hA && k == p2);
      end else begin
        mem_rdy = 1'($urandom_range(0, 1));
      end
      if (instr_ready || k > 90) break;
    end
    if (!instr_ready) check("instr_timeout", instr_ready, 1);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) begin
      @(negedge Clk);
      instr_valid = 1'b0;
      IR = 16'($urandom);
      mem_rdy = rdy ? 1'b1 : 1'($urandom_range(0, 1));
      BEN = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: record strobes per instruction and score them when done appears.
  initial begin
    int ncc, nben, npc, ccc, cben, cpc, rel;
    exp_t e;
    ncc = 0; nben = 0; npc = 0; ccc = 0; cben = 0; cpc = 0;
    forever begin
      @(negedge Clk);
      #1;
      if (!Reset_n) begin
        sb.delete();
        ncc = 0; nben = 0; npc = 0; ccc = 0; cben = 0; cpc = 0;
        continue;
      end
      if (LD_CC || LD_BEN || LD_PC) begin
        check("strobe_onehot", int'(LD_CC) + int'(LD_BEN) + int'(LD_PC), 1);
        if (sb.size() == 0) begin
          check("unexpected_strobe", sb.size(), 1);
        end else begin
          rel = cyc - sb[0].base;
          if (LD_CC)  begin ncc++;  ccc  = rel; end
          if (LD_BEN) begin nben++; cben = rel; end
          if (LD_PC)  begin npc++;  cpc  = rel; end
        end
      end
      if (LD_PC) check("pcmux_taken", PCMUX, 2);
      else if (PCMUX != 2'b00) check("pcmux_idle", PCMUX, 0);
      if (taken) check("taken_with_done", done, 1);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          rel = cyc - e.base;
          check("done_cycle", rel, e.dn);
          check("taken", taken, e.tk);
          check("ld_cc_cycle", ccc, e.cc);
          check("ld_ben_cycle", cben, e.ben);
          check("ld_pc_cycle", cpc, e.pc);
          check("strobe_count", ncc + nben + npc,
                int'(e.cc != 0) + int'(e.ben != 0) + int'(e.pc != 0));
        end
        ncc = 0; nben = 0; npc = 0; ccc = 0; cben = 0; cpc = 0;
      end
    end
  end

  initial begin
    logic [15:0] ir;
    logic [3:0] op;
    int r, p1, p2;
    bit b;

    repeat (3) @(negedge Clk);
    check("rst_instr_ready", instr_ready, 1);
    check("rst_strobes", {LD_CC, LD_BEN, LD_PC, done, taken, PCMUX}, 0);
    Reset_n = 1'b1;
    @(negedge Clk);
    check("rel_instr_ready", instr_ready, 1);
    check("rel_strobes", {LD_CC, LD_BEN, LD_PC, done, taken, PCMUX}, 0);

    issue(16'h1261, 1'b0, 0, 0);
    issue(16'h0405, 1'b1, 0, 0);
    issue(16'h0405, 1'b0, 0, 0);
    issue(16'h0000, 1'b1, 0, 0);
    idle(3, 1'b1);
    issue(16'hA203, 1'b0, 3, 6);
    issue(16'h2203, 1'b0, 2, 0);
    issue(16'h6A41, 1'b0, 5, 0);
    issue(16'hF025, 1'b1, 0, 0);

    // Reset during MEM_WAIT of an LDI that never sees mem_rdy.
    instr_valid = 1'b1;
    IR = 16'hA203;
    mem_rdy = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      instr_valid = 1'b0;
      mem_rdy = 1'b0;
    end
    Reset_n = 1'b0;
    #1;
    check("abort_ready", instr_ready, 1);
    check("abort_ld_cc", LD_CC, 0);
    repeat (2) begin
      @(negedge Clk);
      check("abort_hold_ld_cc", LD_CC, 0);
    end
    Reset_n = 1'b1;
    m_total = 0;
    m_taken = 0;
    @(negedge Clk);
    check("abort_release_ready", instr_ready, 1);
    idle(4, 1'b1);

    issue(16'h0405, 1'b1, 0, 0);
    issue(16'h0405, 1'b1, 0, 0);
    issue(16'h0E07, 1'b1, 0, 0);
    issue(16'h0E07, 1'b0, 0, 0);
`ifdef BRANCH_CC_CTRL_STATS_EN
    check("br_total_dir", br_total, 4);
    check("br_taken_dir", br_taken, 3);
`endif

    repeat (150) begin
      idle($urandom_range(0, 2), 1'b0);
      r = $urandom_range(0, 9);
      if (r <= 2) op = 4'h0;
      else if (r == 3) op = $urandom_range(0, 1) ? 4'h2 : 4'h6;
      else if (r == 4) op = 4'hA;
      else op = 4'($urandom_range(0, 15));
      ir = {op, 12'($urandom)};
      if (op == 4'h0 && $urandom_range(0, 4) == 0) ir[11:9] = 3'b000;
      p1 = $urandom_range(2, 6);
      p2 = p1 + $urandom_range(1, 4);
      b = 1'($urandom_range(0, 1));
      issue(ir, b, p1, p2);
    end

    idle(4, 1'b0);
    check("scoreboard_empty", sb.size(), 0);
`ifdef BRANCH_CC_CTRL_STATS_EN
    check("br_total_end", br_total, m_total);
    check("br_taken_end", br_taken, m_taken);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
